// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Issue/retire stage around a combinational ALU. Incoming commands
// {opcode, A, B} are buffered in a small FIFO and issued one at a time into
// operand registers that drive the ALU inputs directly. After one evaluation
// cycle, the ALU result and carry are captured into a result register.
// Downstream consumes that register through a valid/ready handshake.
//
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_op, cmd_a, cmd_b payload
//   alu_a, alu_b, alu_sel    registered operands to the ALU
//   alu_result, alu_carry    combinational ALU outputs
//   res_valid/res_ready      result handshake
//   res_data, res_carry      captured result; carry is kept only for add (op 0)
//   res_zero                 res_data == 0
//   res_div0                 divide (op 3) issued with B == 0; res_data = all ones
//   cmd_count                FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int WIDTH = 3,
  parameter int SEL_W = 3,
  parameter int DEPTH = 4   // power of 2, >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [SEL_W-1:0]         cmd_op,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_carry,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic                     res_carry,
  output logic                     res_zero,
  output logic                     res_div0,
  output logic [$clog2(DEPTH):0]   cmd_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = SEL_W + 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [SEL_W-1:0]   op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               res_valid_q;
  logic [WIDTH-1:0]   res_data_q;
  logic               res_carry_q;
  logic               res_zero_q;
  logic               res_div0_q;

  logic push;
  logic pop;
  logic fifo_nonempty;
  logic div0;

  // Ready decodes the registered count only, so a pop in the same cycle
  // never frees a slot for a push into a full FIFO.
  assign cmd_ready     = (count_q != CNT_W'(DEPTH));
  assign push          = cmd_valid && cmd_ready;
  assign fifo_nonempty = (count_q != '0);

  // A pop issues the head command: from IDLE whenever something is queued,
  // or from HOLD in the same cycle the pending result is consumed.
  assign pop = fifo_nonempty &&
               ((state_q == IDLE) || ((state_q == HOLD) && res_ready));

  assign div0 = (op_q == SEL_W'(3)) && (b_q == '0);

  // NOTE: FIFO storage has no reset; entries are only read after being
  // written, and the pointers/count that qualify them are reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples values from before the edge, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      res_div0_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q            <= rd_ptr_q + PTR_W'(1);
        {op_q, a_q, b_q}    <= mem_q[rd_ptr_q];
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      case (state_q)
        IDLE: begin
          if (pop) begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // The ALU has had the whole cycle to settle on stable operands.
          res_data_q  <= div0 ? '1 : alu_result;
          res_carry_q <= alu_carry && (op_q == '0) && !div0;
          res_zero_q  <= !div0 && (alu_result == '0);
          res_div0_q  <= div0;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= pop ? EXEC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_sel   = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_zero  = res_zero_q;
  assign res_div0  = res_div0_q;
  assign cmd_count = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Drives alu_cmd_sequencer with directed scenarios followed by randomized
// traffic. The bench also provides the external combinational ALU. A scoreboard
// holds the expected result for every accepted command, in order, and checks
// each retired result against it.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  localparam int WIDTH = 3;
  localparam int SEL_W = 3;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0] data;
    logic       carry;
    logic       zero;
    logic       div0;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_a;
  logic [2:0] cmd_b;
  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic [2:0] alu_sel;
  logic [2:0] alu_result;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready;
  logic [2:0] res_data;
  logic       res_carry;
  logic       res_zero;
  logic       res_div0;
  logic [2:0] cmd_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_retired = 0;

  exp_t exp_q[$];

  alu_cmd_sequencer #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_carry  (res_carry),
    .res_zero   (res_zero),
    .res_div0   (res_div0),
    .cmd_count  (cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External 3-bit ALU: {carry, result}. Several non-add ops produce a
  // nonzero carry so that carry masking is observable.
  function automatic logic [3:0] alu_ref(logic [2:0] op, logic [2:0] a, logic [2:0] b);
    logic [5:0] p;
    logic [3:0] r;
    p = {3'b000, a} * {3'b000, b};
    case (op)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {|p[5:3], p[2:0]};
      3'd3:    r = (b == 3'd0) ? 4'b1000 : {1'b1, a / b};
      3'd4:    r = {1'b1, a & b};
      3'd5:    r = {1'b1, a | b};
      3'd6:    r = {1'b0, a ^ b};
      default: r = {1'b1, ~a};
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_result} = alu_ref(alu_sel, alu_a, alu_b);

  // Expected retired result for one command.
  function automatic exp_t model(logic [2:0] op, logic [2:0] a, logic [2:0] b);
    logic [3:0] r;
    exp_t e;
    r = alu_ref(op, a, b);
    if (op == 3'd3 && b == 3'd0) begin
      e = '{data: 3'b111, carry: 1'b0, zero: 1'b0, div0: 1'b1};
    end else begin
      e = '{data: r[2:0], carry: (op == 3'd0) ? r[3] : 1'b0,
            zero: (r[2:0] == 3'd0), div0: 1'b0};
    end
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor at the falling edge: inputs were driven just after the rising
  // edge, so these are the values the next rising edge will act on.
  logic       prev_hold = 1'b0;
  logic [5:0] prev_res;
  logic [8:0] prev_alu;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", res_valid, 1);
        check("hold_result", {res_data, res_carry, res_zero, res_div0}, prev_res);
        check("hold_operands", {alu_sel, alu_a, alu_b}, prev_alu);
      end
      check("ready_decode", cmd_ready, (cmd_count != 3'(DEPTH)));
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(model(cmd_op, cmd_a, cmd_b));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", res_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_data",  res_data,  e.data);
          check("res_carry", res_carry, e.carry);
          check("res_zero",  res_zero,  e.zero);
          check("res_div0",  res_div0,  e.div0);
        end
        n_retired++;
      end
      prev_hold = res_valid && !res_ready;
      prev_res  = {res_data, res_carry, res_zero, res_div0};
      prev_alu  = {alu_sel, alu_a, alu_b};
    end
  end

  // Single command into an idle block with res_ready=1; checks the latency
  // profile and the result flags.
  task automatic run_one(string tag, logic [2:0] op, logic [2:0] a, logic [2:0] b,
                         logic [2:0] e_data, logic e_carry, logic e_zero, logic e_div0);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    step();                                  // accept edge N
    cmd_valid = 1'b0;
    check({tag, "_valid_n1"}, res_valid, 0);
    step();                                  // EXEC
    check({tag, "_valid_n2"}, res_valid, 0);
    check({tag, "_alu_ops"}, {alu_sel, alu_a, alu_b}, {op, a, b});
    step();                                  // result registered
    check({tag, "_valid_n3"}, res_valid, 1);
    check({tag, "_data"},  res_data,  e_data);
    check({tag, "_carry"}, res_carry, e_carry);
    check({tag, "_zero"},  res_zero,  e_zero);
    check({tag, "_div0"},  res_div0,  e_div0);
    step();
    check({tag, "_valid_drop"}, res_valid, 0);
  endtask

  initial begin
    int base;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_ready", cmd_ready, 1);
    check("rst_count", cmd_count, 0);
    check("rst_valid", res_valid, 0);
    check("rst_res",   {res_data, res_carry, res_zero, res_div0}, 0);
    check("rst_alu",   {alu_sel, alu_a, alu_b}, 0);

    // Add with carry, then divide by zero, then subtract to zero.
    res_ready = 1'b1;
    step();
    run_one("add", 3'd0, 3'd5, 3'd6, 3'd3, 1'b1, 1'b0, 1'b0);
    run_one("div0", 3'd3, 3'd7, 3'd0, 3'd7, 1'b0, 1'b0, 1'b1);
    run_one("sub0", 3'd1, 3'd4, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0);

    // FIFO full under backpressure.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'(i); cmd_a = 3'(i + 2); cmd_b = 3'(7 - i);
      step();
    end
    check("full_count", cmd_count, 4);
    check("full_ready", cmd_ready, 0);
    cmd_op = 3'd6; cmd_a = 3'd1; cmd_b = 3'd2;   // 6th offer, must be refused
    step(); step();
    check("full_count_hold", cmd_count, 4);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    base = n_retired;
    for (int i = 0; i < 8; i++) step();
    check("drain_rate_8", n_retired - base, 4);
    step();
    check("drain_rate_9", n_retired - base, 5);
    check("drain_count", cmd_count, 0);
    step();
    check("drain_idle", res_valid, 0);

    // Backpressure hold on an AND result.
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 3'd6; cmd_b = 3'd3;
    step();
    cmd_valid = 1'b0;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", res_valid, 1);
      check("bp_data", res_data, 2);
      check("bp_operands", {alu_sel, alu_a, alu_b}, {3'd4, 3'd6, 3'd3});
      step();
    end
    res_ready = 1'b1;
    step(); step();

    // Reset while EXEC is in progress with three commands queued.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'(i + 1); cmd_a = 3'(i); cmd_b = 3'(i + 1);
      if (i == 4) res_ready = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    check("pre_rst_count", cmd_count, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_count", cmd_count, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_sel",   alu_sel, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_quiet", res_valid, 0);
    end

    // Randomized traffic with occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_a     = 3'($urandom_range(0, 7));
      cmd_b     = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      res_ready = ($urandom_range(0, 9) < 6);
      rst       = ($urandom_range(0, 399) == 0);
      step();
    end

    // Drain with a bounded wait.
    rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !res_valid && cmd_count == 0) break;
      step();
    end
    check("final_pending", exp_q.size(), 0);
    check("final_count", cmd_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
